pll_reset_sequencer: RTL and testbench

//  Sequences the system PLL and the per-domain resets on the 50MHz board clock.

---
 rtl/pll_reset_seq_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and width helpers for the PLL / domain reset sequencer.
// The state encoding is exported on oSTATE for debug.
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } seqState_t;

  localparam int SYNC_STAGES = 2;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..maxVal without wrapping.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the 'clock' domain.
// A synchronous active-high reset forces both flops to P_RESET_VALUE.
module sync_2ff #(
  parameter logic P_RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= P_RESET_VALUE;
      q    <= P_RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable lock (with timeout and retry budget),
// then releases the MAIN, VGA and ASMI domain resets in staged order.
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int P_PLL_RST_CYCLES = 16,
  parameter int P_LOCK_TIMEOUT   = 65536,
  parameter int P_STABLE_CYCLES  = 1024,
  parameter int P_STAGE_GAP      = 64,
  parameter int P_MAX_RETRY      = 4
) (
  input  logic       iCLOCK,
  input  logic       iRESET_SYNC,
  input  logic       iPLL_LOCK,
  input  logic       iREQ_RESTART,
  output logic       oPLL_RST,
  output logic       oRESET_MAIN,
  output logic       oRESET_VGA,
  output logic       oRESET_ASMI,
  output logic       oSYSTEM_READY,
  output logic       oFAIL,
  output logic [2:0] oSTATE
);

  localparam int CNT_MAX = maxOf(maxOf(P_PLL_RST_CYCLES, P_LOCK_TIMEOUT),
                                 maxOf(P_STABLE_CYCLES, 2 * P_STAGE_GAP));
  localparam int CNT_W   = cntWidth(CNT_MAX);
  localparam int RETRY_W = cntWidth(P_MAX_RETRY);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(P_PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(P_LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(P_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   VGA_LAST    = CNT_W'(P_STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]   ASMI_LAST   = CNT_W'(2 * P_STAGE_GAP - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(P_MAX_RETRY);

  logic               lockS;
  seqState_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cntInc;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retryInc;
  logic               abortSeq;

  sync_2ff #(
    .P_RESET_VALUE(1'b0)
  ) uLockSync (
    .clock(iCLOCK),
    .reset(iRESET_SYNC),
    .d    (iPLL_LOCK),
    .q    (lockS)
  );

  // Saturating increments, plus the condition that throws every domain back
  // into reset: an explicit restart, or lock lost once resets are being released.
  always_comb begin
    cntInc = cnt;
    if (cnt != '1) cntInc = cnt + 1'b1;
    retryInc = retry;
    if (retry != RETRY_MAX) retryInc = retry + 1'b1;
    abortSeq = iREQ_RESTART | (((state == RELEASE) || (state == RUN)) && !lockS);
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state         <= PLL_RESET;
      cnt           <= '0;
      retry         <= '0;
      oPLL_RST      <= 1'b1;
      oRESET_MAIN   <= 1'b1;
      oRESET_VGA    <= 1'b1;
      oRESET_ASMI   <= 1'b1;
      oSYSTEM_READY <= 1'b0;
      oFAIL         <= 1'b0;
    end else if (abortSeq) begin
      state         <= PLL_RESET;
      cnt           <= '0;
      oPLL_RST      <= 1'b1;
      oRESET_MAIN   <= 1'b1;
      oRESET_VGA    <= 1'b1;
      oRESET_ASMI   <= 1'b1;
      oSYSTEM_READY <= 1'b0;
      oFAIL         <= 1'b0;
      if (iREQ_RESTART) retry <= '0;
    end else begin
      case (state)
        PLL_RESET: begin
          oPLL_RST <= 1'b1;
          if (cnt == RST_LAST) begin
            state    <= WAIT_LOCK;
            cnt      <= '0;
            oPLL_RST <= 1'b0;
          end else begin
            cnt <= cntInc;
          end
        end
        WAIT_LOCK: begin
          if (lockS) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry <= retryInc;
            cnt   <= '0;
            if (retryInc == RETRY_MAX) begin
              state <= FAIL;
              oFAIL <= 1'b1;
            end else begin
              state    <= PLL_RESET;
              oPLL_RST <= 1'b1;
            end
          end else begin
            cnt <= cntInc;
          end
        end
        STABLE: begin
          if (!lockS) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= RELEASE;
            cnt         <= '0;
            retry       <= '0;
            oRESET_MAIN <= 1'b0;
          end else begin
            cnt <= cntInc;
          end
        end
        RELEASE: begin
          cnt <= cntInc;
          if (cnt == VGA_LAST) oRESET_VGA <= 1'b0;
          if (cnt == ASMI_LAST) begin
            state         <= RUN;
            oRESET_ASMI   <= 1'b0;
            oSYSTEM_READY <= 1'b1;
          end
        end
        RUN: begin
          oSYSTEM_READY <= 1'b1;
        end
        FAIL: begin
          oFAIL    <= 1'b1;
          oPLL_RST <= 1'b0;
        end
        default: begin
          state    <= PLL_RESET;
          cnt      <= '0;
          oPLL_RST <= 1'b1;
        end
      endcase
    end
  end

  assign oSTATE = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with small parameters
// (RST=4, TIMEOUT=100, STABLE=20, GAP=8, RETRY=3).
module tb_pll_reset_sequencer;
  import pll_reset_seq_pkg::*;

  logic       iCLOCK;
  logic       iRESET_SYNC;
  logic       iPLL_LOCK;
  logic       iREQ_RESTART;
  logic       oPLL_RST;
  logic       oRESET_MAIN;
  logic       oRESET_VGA;
  logic       oRESET_ASMI;
  logic       oSYSTEM_READY;
  logic       oFAIL;
  logic [2:0] oSTATE;

  int total = 0;
  int bad   = 0;

  pll_reset_sequencer #(
    .P_PLL_RST_CYCLES(4),
    .P_LOCK_TIMEOUT  (100),
    .P_STABLE_CYCLES (20),
    .P_STAGE_GAP     (8),
    .P_MAX_RETRY     (3)
  ) dut (
    .iCLOCK       (iCLOCK),
    .iRESET_SYNC  (iRESET_SYNC),
    .iPLL_LOCK    (iPLL_LOCK),
    .iREQ_RESTART (iREQ_RESTART),
    .oPLL_RST     (oPLL_RST),
    .oRESET_MAIN  (oRESET_MAIN),
    .oRESET_VGA   (oRESET_VGA),
    .oRESET_ASMI  (oRESET_ASMI),
    .oSYSTEM_READY(oSYSTEM_READY),
    .oFAIL        (oFAIL),
    .oSTATE       (oSTATE)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // Advance n rising edges, then settle 1 time unit so outputs are stable.
  task automatic step(input int n);
    repeat (n) @(posedge iCLOCK);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic lock, input logic restart);
    iRESET_SYNC  = rst;
    iPLL_LOCK    = lock;
    iREQ_RESTART = restart;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic pll, input logic rstAll,
                          input logic ready, input logic fail, input seqState_t st);
    checkOutput({tag, ".pll"},   8'(oPLL_RST),      8'(pll));
    checkOutput({tag, ".main"},  8'(oRESET_MAIN),   8'(rstAll));
    checkOutput({tag, ".vga"},   8'(oRESET_VGA),    8'(rstAll));
    checkOutput({tag, ".asmi"},  8'(oRESET_ASMI),   8'(rstAll));
    checkOutput({tag, ".ready"}, 8'(oSYSTEM_READY), 8'(ready));
    checkOutput({tag, ".fail"},  8'(oFAIL),         8'(fail));
    checkOutput({tag, ".state"}, 8'(oSTATE),        8'(st));
  endtask

  // Called right after lock is raised in WAIT_LOCK. Edge 1/2 fill the
  // synchronizer, edge 3 enters STABLE, 20 more locked edges release MAIN
  // (edge 23), VGA follows 8 edges later, ASMI and READY 16 edges later.
  task automatic releaseAndCheck(input string tag);
    step(2);  checkOutput({tag, ".syncDelay"}, 8'(oSTATE), 8'(WAIT_LOCK));
    step(1);  checkOutput({tag, ".stable"},    8'(oSTATE), 8'(STABLE));
    step(19); checkOutput({tag, ".mainHeld"},  8'(oRESET_MAIN), 8'd1);
    step(1);  checkOutput({tag, ".mainRel"},   8'(oRESET_MAIN), 8'd0);
              checkOutput({tag, ".release"},   8'(oSTATE), 8'(RELEASE));
    step(7);  checkOutput({tag, ".vgaHeld"},   8'(oRESET_VGA), 8'd1);
    step(1);  checkOutput({tag, ".vgaRel"},    8'(oRESET_VGA), 8'd0);
    step(7);  checkOutput({tag, ".asmiHeld"},  8'(oRESET_ASMI), 8'd1);
              checkOutput({tag, ".readyLow"},  8'(oSYSTEM_READY), 8'd0);
    step(1);  checkOutput({tag, ".asmiRel"},   8'(oRESET_ASMI), 8'd0);
              checkOutput({tag, ".ready"},     8'(oSYSTEM_READY), 8'd1);
              checkOutput({tag, ".run"},       8'(oSTATE), 8'(RUN));
              checkOutput({tag, ".mainStays"}, 8'(oRESET_MAIN), 8'd0);
  endtask

  initial begin
    // Power-on reset, then a normal bring-up with lock 10 cycles into WAIT_LOCK.
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(2);
    checkAll("reset", 1'b1, 1'b1, 1'b0, 1'b0, PLL_RESET);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(3); checkOutput("t1.pllHigh", 8'(oPLL_RST), 8'd1);
    step(1); checkOutput("t1.pllLow",  8'(oPLL_RST), 8'd0);
             checkOutput("t1.wait",    8'(oSTATE),   8'(WAIT_LOCK));
    step(10); checkOutput("t1.stillWait", 8'(oSTATE), 8'(WAIT_LOCK));
    iPLL_LOCK = 1'b1;
    releaseAndCheck("t1");

    // Lock loss in RUN: three edges later everything is back in reset.
    step(5);
    iPLL_LOCK = 1'b0;
    step(2); checkOutput("t4.readyHeld", 8'(oSYSTEM_READY), 8'd1);
             checkOutput("t4.mainHeld",  8'(oRESET_MAIN),   8'd0);
    step(1); checkAll("t4.lost", 1'b1, 1'b1, 1'b0, 1'b0, PLL_RESET);
    step(3); checkOutput("t4.pllHigh", 8'(oPLL_RST), 8'd1);
    step(1); checkOutput("t4.pllLow",  8'(oPLL_RST), 8'd0);
             checkOutput("t4.wait",    8'(oSTATE),   8'(WAIT_LOCK));
    iPLL_LOCK = 1'b1;
    releaseAndCheck("t4");

    // Synchronous reset mid-RUN.
    step(4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    checkAll("t6", 1'b1, 1'b1, 1'b0, 1'b0, PLL_RESET);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Lock never arrives: three 4-cycle PLL pulses, 100 idle cycles each, then FAIL.
    for (int p = 0; p < 3; p++) begin
      step(3);  checkOutput($sformatf("t2.p%0d.high", p), 8'(oPLL_RST), 8'd1);
      step(1);  checkOutput($sformatf("t2.p%0d.low", p),  8'(oPLL_RST), 8'd0);
      step(99); checkOutput($sformatf("t2.p%0d.wait", p), 8'(oSTATE),   8'(WAIT_LOCK));
                checkOutput($sformatf("t2.p%0d.noFail", p), 8'(oFAIL),  8'd0);
      step(1);
      if (p < 2) begin
        checkOutput($sformatf("t2.p%0d.retry", p), 8'(oSTATE), 8'(PLL_RESET));
        checkOutput($sformatf("t2.p%0d.pllUp", p), 8'(oPLL_RST), 8'd1);
      end else begin
        checkAll("t2.fail", 1'b0, 1'b1, 1'b0, 1'b1, FAIL);
      end
    end
    step(5);
    checkAll("t2.sticky", 1'b0, 1'b1, 1'b0, 1'b1, FAIL);
    iREQ_RESTART = 1'b1;
    step(1);
    iREQ_RESTART = 1'b0;
    checkAll("t2.restart", 1'b1, 1'b1, 1'b0, 1'b0, PLL_RESET);

    // One-cycle lock glitch at STABLE count 15 forces a fresh 20-cycle window.
    step(3); checkOutput("t3.pllHigh", 8'(oPLL_RST), 8'd1);
    step(1); checkOutput("t3.wait",    8'(oSTATE),   8'(WAIT_LOCK));
    iPLL_LOCK = 1'b1;
    step(18); checkOutput("t3.stable15", 8'(oSTATE), 8'(STABLE));
    iPLL_LOCK = 1'b0;
    step(1);
    iPLL_LOCK = 1'b1;
    step(1);  checkOutput("t3.stillStable", 8'(oSTATE), 8'(STABLE));
    step(1);  checkOutput("t3.backToWait",  8'(oSTATE), 8'(WAIT_LOCK));
    step(1);  checkOutput("t3.restable",    8'(oSTATE), 8'(STABLE));
    step(19); checkOutput("t3.mainHeld",    8'(oRESET_MAIN), 8'd1);
    step(1);  checkOutput("t3.mainRel",     8'(oRESET_MAIN), 8'd0);

    // Restart during RELEASE once VGA is out of reset.
    step(8);
    checkOutput("t5.vgaRel", 8'(oRESET_VGA), 8'd0);
    checkOutput("t5.asmiHeld", 8'(oRESET_ASMI), 8'd1);
    iREQ_RESTART = 1'b1;
    step(1);
    iREQ_RESTART = 1'b0;
    checkAll("t5", 1'b1, 1'b1, 1'b0, 1'b0, PLL_RESET);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
